// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, single-word refill on miss.
// Optional hit/miss counters are compiled in when ICACHE_PERF_EN is defined.
module icache_dm #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic [1:0]  fsm_state
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILL        = 2'd1,
    REFILL_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [31:0]      data_arr [SETS];

  logic [31:0]      miss_addr;
  logic             fill_kill;
  logic             miss_start;
  logic             fill_done;
  logic             lookup_hit;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign req_idx   = imemaddr[IDX_W+1:2];
  assign req_tag   = imemaddr[31:IDX_W+2];
  assign fill_idx  = miss_addr[IDX_W+1:2];
  assign fill_tag  = miss_addr[31:IDX_W+2];
  assign fill_done = (state == FILL) && !iwait;
  assign fsm_state = state;

  assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  // Handshake: memory data is taken in any FILL cycle with iREN=1 and iwait=0;
  // iREN/iaddr hold steady for the whole FILL state and are zero elsewhere.
  always_comb begin
    state_n    = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    miss_start = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit = !iflush;
          end else begin
            miss_start = 1'b1;
            state_n    = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) state_n = REFILL_DONE;
      end
      REFILL_DONE: state_n = IDLE;
      default:     state_n = IDLE;
    endcase
    if (ihit) imemload = data_arr[req_idx];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
      fill_kill <= 1'b0;
    end else begin
      state <= state_n;
      if (miss_start) miss_addr <= imemaddr & 32'hFFFF_FFFC;
      // A flush seen at any point of a fill keeps that frame invalid on completion.
      if (miss_start)                   fill_kill <= 1'b0;
      else if (state == FILL && iflush) fill_kill <= 1'b1;
      if (iflush) valid <= '0;
      if (fill_done && !iflush && !fill_kill) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold/warm/conflict misses, redirect, flush and reset cases.
// Counter checks are included when ICACHE_PERF_EN is defined.
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [1:0]  fsm_state;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] D40  = 32'h2408_0005;
  localparam logic [31:0] D440 = 32'h8C22_0000;
  localparam logic [31:0] D44  = 32'h1111_0044;
  localparam logic [31:0] D48  = 32'h2222_0048;
  localparam logic [31:0] D80  = 32'hAAAA_0080;
  localparam logic [31:0] D100 = 32'h5555_0100;

  icache_dm #(.SETS(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iflush    (iflush),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
`ifdef ICACHE_PERF_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .fsm_state (fsm_state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Full miss sequence from IDLE: nwait busy cycles, data cycle, REFILL_DONE, then the hit.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int nwait);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = 32'h0;
    settle();
    chk("miss_ihit", {31'b0, ihit}, 32'd0);
    chk("miss_iren_idle", {31'b0, iREN}, 32'd0);
    tick();
    chk("fill_state", {30'b0, fsm_state}, 32'd1);
    for (int i = 0; i < nwait; i++) begin
      settle();
      chk("fill_iren", {31'b0, iREN}, 32'd1);
      chk("fill_iaddr", iaddr, a & 32'hFFFF_FFFC);
      chk("fill_ihit", {31'b0, ihit}, 32'd0);
      tick();
    end
    iwait = 1'b0;
    iload = d;
    settle();
    chk("fill_last_iren", {31'b0, iREN}, 32'd1);
    chk("fill_last_iaddr", iaddr, a & 32'hFFFF_FFFC);
    tick();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    settle();
    chk("rd_iren", {31'b0, iREN}, 32'd0);
    chk("rd_ihit", {31'b0, ihit}, 32'd0);
    chk("rd_state", {30'b0, fsm_state}, 32'd2);
    tick();
    settle();
    chk("hit_after_fill", {31'b0, ihit}, 32'd1);
    chk("load_after_fill", imemload, d);
    tick();
  endtask

  initial begin
    // Reset
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b1; iload = 32'h0;
    tick(); tick();
    nRST = 1'b1;
    settle();
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_state", {30'b0, fsm_state}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    tick();

    // Cold miss: two busy cycles, iREN high for three cycles
    do_miss(32'h0000_0040, D40, 2);

    // Warm hit: same-cycle hit, no memory request
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    settle();
    chk("warm_ihit", {31'b0, ihit}, 32'd1);
    chk("warm_load", imemload, D40);
    chk("warm_iren", {31'b0, iREN}, 32'd0);
    tick();
    chk("warm_state", {30'b0, fsm_state}, 32'd0);
    chk("warm_iren_next", {31'b0, iREN}, 32'd0);

    // Fetch disabled: no hit, zero load, no miss
    imemREN = 1'b0;
    settle();
    chk("noren_ihit", {31'b0, ihit}, 32'd0);
    chk("noren_load", imemload, 32'd0);
    tick();
    chk("noren_state", {30'b0, fsm_state}, 32'd0);

    // Conflict on index 0
    do_miss(32'h0000_0440, D440, 1);
    do_miss(32'h0000_0040, D40, 0);

    // Redirect mid-fill
    imemREN = 1'b1; imemaddr = 32'h0000_0080; iwait = 1'b1;
    settle();
    chk("redir_miss", {31'b0, ihit}, 32'd0);
    tick();
    imemaddr = 32'h0000_0100;
    settle();
    chk("redir_iaddr", iaddr, 32'h0000_0080);
    chk("redir_ihit", {31'b0, ihit}, 32'd0);
    iwait = 1'b0; iload = D80;
    settle();
    chk("redir_iaddr_last", iaddr, 32'h0000_0080);
    tick();
    iwait = 1'b1;
    settle();
    chk("redir_rd_ihit", {31'b0, ihit}, 32'd0);
    tick();
    imemaddr = 32'h0000_0080;
    settle();
    chk("redir_frame_hit", {31'b0, ihit}, 32'd1);
    chk("redir_frame_load", imemload, D80);
    imemaddr = 32'h0000_0100;
    settle();
    chk("redir_new_miss", {31'b0, ihit}, 32'd0);
    tick();
    settle();
    chk("redir_new_iaddr", iaddr, 32'h0000_0100);
    iwait = 1'b0; iload = D100;
    tick();
    iwait = 1'b1;
    tick();
    settle();
    chk("redir_new_hit", {31'b0, ihit}, 32'd1);
    chk("redir_new_load", imemload, D100);
    tick();

    // Flush in IDLE
    do_miss(32'h0000_0040, D40, 0);
    do_miss(32'h0000_0044, D44, 0);
    imemREN = 1'b0; iflush = 1'b1;
    settle();
    chk("flush_ihit", {31'b0, ihit}, 32'd0);
    tick();
    iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h0000_0040;
    settle();
    chk("flush_40_miss", {31'b0, ihit}, 32'd0);
    imemaddr = 32'h0000_0044;
    settle();
    chk("flush_44_miss", {31'b0, ihit}, 32'd0);
    imemREN = 1'b0;
    tick();

    // Flush during fill of 0x48
    do_miss(32'h0000_0044, D44, 0);
    imemREN = 1'b1; imemaddr = 32'h0000_0048; iwait = 1'b1;
    settle();
    tick();
    iflush = 1'b1;
    settle();
    chk("flushfill_iren", {31'b0, iREN}, 32'd1);
    tick();
    iflush = 1'b0; iwait = 1'b0; iload = D48;
    tick();
    iwait = 1'b1;
    tick();
    imemaddr = 32'h0000_0044;
    settle();
    chk("flushfill_44_miss", {31'b0, ihit}, 32'd0);
    imemaddr = 32'h0000_0048;
    settle();
    chk("flushfill_48_miss", {31'b0, ihit}, 32'd0);
    imemREN = 1'b0;
    tick();
    do_miss(32'h0000_0048, D48, 0);

    // Reset mid-fill
    do_miss(32'h0000_0040, D40, 0);
    imemREN = 1'b1; imemaddr = 32'h0000_004C; iwait = 1'b1;
    settle();
    tick();
    nRST = 1'b0;
    settle();
    chk("rstfill_iren_before", {31'b0, iREN}, 32'd1);
    tick();
    nRST = 1'b1; imemREN = 1'b0;
    settle();
    chk("rstfill_iren", {31'b0, iREN}, 32'd0);
    chk("rstfill_iaddr", iaddr, 32'd0);
    chk("rstfill_ihit", {31'b0, ihit}, 32'd0);
    chk("rstfill_load", imemload, 32'd0);
    chk("rstfill_state", {30'b0, fsm_state}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("rstfill_hit_count", hit_count, 32'd0);
    chk("rstfill_miss_count", miss_count, 32'd0);
`endif
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    settle();
    chk("rstfill_40_miss", {31'b0, ihit}, 32'd0);
    imemREN = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
